// File: rtl/regfile_mp.sv
// Multi-ported register file with self-clearing init FSM and hardwired-zero r0.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                we,
  output logic                ready,
  output logic [0:0]          o_dbg_state
);

  localparam logic [0:0]    ST_CLEAR = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Valid/ready note: writes have no handshake. ready=1 means a write with
  // we=1 and wa!=0 is committed on that edge; while ready=0 writes are dropped.

  logic [0:0]      r_state;
  logic [AW-1:0]   r_cnt;
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic [XLEN-1:0] w_regs [0:NREGS-1];
  logic            w_run;
  logic            w_wr_ok;
  logic [AW-1:0]   w_rsel;

  assign w_run       = (r_state == ST_RUN);
  assign w_wr_ok     = w_run && we && (wa != '0);
  assign ready       = w_run;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= AW'(1);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // Counter stops on the last index instead of wrapping.
          if (r_cnt == CNT_LAST) r_state <= ST_RUN;
          else                   r_cnt   <= r_cnt + AW'(1);
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Storage is never touched on a reset edge; r0 has no storage at all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k < NREGS; k++) begin
        if (r_state == ST_CLEAR) begin
          if (r_cnt == AW'(k)) r_regs[k] <= '0;
        end else if (w_wr_ok && (wa == AW'(k))) begin
          r_regs[k] <= wd;
        end
      end
    end
  end

  assign w_regs[0] = '0;
  for (genvar g = 1; g < NREGS; g++) begin : g_view
    assign w_regs[g] = r_regs[g];
  end

  always_comb begin
    rd     = '0;
    w_rsel = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rsel = ra[i*AW +: AW];
      if (w_run && (w_rsel != '0)) begin
        if (BYPASS_EN && w_wr_ok && (w_rsel == wa)) rd[i*XLEN +: XLEN] = wd;
        else                                        rd[i*XLEN +: XLEN] = w_regs[w_rsel];
      end
    end
  end

  a_cnt_nonzero: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_CLEAR) |-> (r_cnt != '0));

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (XLEN=32, NREGS=32, NRD=3).
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 3;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                we;
  logic                ready;
  logic [0:0]          dbg_state;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .wa(wa), .wd(wd), .we(we),
    .ready(ready), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [XLEN-1:0] mdl [NREGS];
  logic [XLEN-1:0] exp_q [$];

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   ra0, ra1, ra2;
    logic [XLEN-1:0] e0, e1, e2;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endtask

  function automatic logic [XLEN-1:0] port(input int i);
    return rd[i*XLEN +: XLEN];
  endfunction

  // Driver tasks
  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
    if (a != '0) mdl[a] = d;
  endtask

  task automatic wait_clear(input bit inject, output int n);
    int bad;
    n = 0; bad = 0;
    set_ra(5'd3, 5'd5, 5'd31);
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 1) begin we = 1'b1; wa = 5'd3; wd = 32'h55; end
      if (inject && n == 2) we = 1'b0;
      #1;
      if (ready !== 1'b1 && (port(0) !== '0 || port(1) !== '0 || port(2) !== '0)) bad++;
    end
    we = 1'b0;
    chk("clear_rd_zero", XLEN'(bad), '0);
    for (int k = 0; k < NREGS; k++) mdl[k] = '0;
  endtask

  task automatic read_all(input string name);
    for (int base = 0; base < NREGS; base += 3) begin
      set_ra(AW'(base), AW'((base + 1) % NREGS), AW'((base + 2) % NREGS));
      for (int j = 0; j < NRD; j++) exp_q.push_back(mdl[(base + j) % NREGS]);
      #1;
      for (int j = 0; j < NRD; j++) chk(name, port(j), exp_q.pop_front());
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;

    // Reset state
    @(posedge clk); #1;
    set_ra(5'd1, 5'd2, 5'd31); #1;
    chk("reset_ready", XLEN'(ready), '0);
    chk("reset_state", XLEN'(dbg_state), '0);
    chk("reset_rd", rd[XLEN-1:0] | rd[2*XLEN-1:XLEN] | rd[3*XLEN-1:2*XLEN], '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Clear sequence with a dropped write to r3 on cycle 2
    wait_clear(1'b1, n);
    chk("clear_edges", XLEN'(n), 32'd31);
    read_all("clear_readall");

    // Table of vectors: inputs applied, comb rd checked, then clocked
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd0,  5'd0,
                32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, 5'd0,
                32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0, 5'd5, 5'd31, 5'd0,
                32'hDEADBEEF, 32'h12345678, 32'h0};
    tbl[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0, 5'd0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 5'd7,  32'h1, 5'd7, 5'd5, 5'd7,
                BYP ? 32'h1 : 32'h0, 32'hDEADBEEF, BYP ? 32'h1 : 32'h0};
    tbl[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd31, 5'd7,
                BYP ? 32'hA5A5A5A5 : 32'h1, 32'h12345678, BYP ? 32'hA5A5A5A5 : 32'h1};
    tbl[7]  = '{1'b0, 5'd0,  32'h0, 5'd7, 5'd7, 5'd7,
                32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[8]  = '{1'b1, 5'd5,  32'h0, 5'd5, 5'd5, 5'd31,
                BYP ? 32'h0 : 32'hDEADBEEF, BYP ? 32'h0 : 32'hDEADBEEF, 32'h12345678};
    tbl[9]  = '{1'b0, 5'd0,  32'h0, 5'd5, 5'd7, 5'd31,
                32'h0, 32'hA5A5A5A5, 32'h12345678};
    tbl[10] = '{1'b1, 5'd1,  32'h80000001, 5'd1, 5'd2, 5'd3,
                BYP ? 32'h80000001 : 32'h0, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 5'd0,  32'h0, 5'd1, 5'd30, 5'd3,
                32'h80000001, 32'h0, 32'h0};

    for (int v = 0; v < 12; v++) begin
      we = tbl[v].we; wa = tbl[v].wa; wd = tbl[v].wd;
      set_ra(tbl[v].ra0, tbl[v].ra1, tbl[v].ra2);
      #1;
      chk($sformatf("vec%0d_p0", v), port(0), tbl[v].e0);
      chk($sformatf("vec%0d_p1", v), port(1), tbl[v].e1);
      chk($sformatf("vec%0d_p2", v), port(2), tbl[v].e2);
      @(posedge clk); #1;
    end
    we = 1'b0;

    // Fill r1..r31, read back, then reset mid-RUN
    for (int k = 1; k < NREGS; k++) wr(AW'(k), 32'h1000_0000 + k * 32'h0101_0101);
    read_all("fill_readall");
    set_ra(5'd1, 5'd17, 5'd31);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrun_ready", XLEN'(ready), '0);
    chk("midrun_rd0", port(0), '0);
    chk("midrun_rd2", port(2), '0);
    reset = 1'b0;
    wait_clear(1'b0, n);
    chk("midrun_clear_edges", XLEN'(n), 32'd31);
    read_all("midrun_readall");

    // Reset mid-CLEAR when counter reaches 10
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midclear_not_ready", XLEN'(ready), '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midclear_state", XLEN'(dbg_state), '0);
    wait_clear(1'b0, n);
    chk("midclear_edges", XLEN'(n), 32'd31);
    wr(5'd12, 32'hCAFEF00D);
    set_ra(5'd12, 5'd12, 5'd0); #1;
    chk("post_wr_p0", port(0), 32'hCAFEF00D);
    chk("post_wr_p1", port(1), 32'hCAFEF00D);
    chk("post_wr_p2", port(2), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
